// File: rtl/ras_update_sched_if.sv
// Flush type and the decode/RAS handshake bundle for ras_update_sched.
// The slave modport is the scheduler's view; master is the decode/RAS side.
package ras_update_sched_pkg;
  typedef struct packed {
    logic valid;
  } flush_t;
endpackage

interface ras_update_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_pc;
  logic [4:0]       in0_rs1;
  logic [4:0]       in0_rd;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_pc;
  logic [4:0]       in1_rs1;
  logic [4:0]       in1_rd;
  logic             in_ready;
  logic             out_valid;
  logic [1:0]       out_op;
  logic [WIDTH-1:0] out_pc;
  logic             out_ready;

  modport slave (
    input  in0_valid, in0_pc, in0_rs1, in0_rd,
    input  in1_valid, in1_pc, in1_rs1, in1_rd,
    output in_ready,
    output out_valid, out_op, out_pc,
    input  out_ready
  );

  modport master (
    output in0_valid, in0_pc, in0_rs1, in0_rd,
    output in1_valid, in1_pc, in1_rs1, in1_rd,
    input  in_ready,
    input  out_valid, out_op, out_pc,
    output out_ready
  );
endinterface

// File: rtl/ras_update_sched.sv
// Classifies two decode lanes' JAL/JALR into RAS push/pop ops and issues them in order, one per cycle.
// Optional saturating statistics outputs are enabled by defining RAS_SCHED_STATS_EN.
module ras_update_sched
  import ras_update_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  flush_t               flush,
  ras_update_sched_if.slave    bus
`ifdef RAS_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_push,
  output logic [15:0]          stat_pop,
  output logic [15:0]          stat_flush_drop
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_POPPUSH = 2'b11
  } ras_op_e;

  typedef struct packed {
    ras_op_e          op;
    logic [WIDTH-1:0] pc;
  } entry_t;

  function automatic ras_op_e classify(input logic [4:0] rd, input logic [4:0] rs1);
    logic ld;
    logic ls;
    ld = (rd == 5'd1) || (rd == 5'd5);
    ls = (rs1 == 5'd1) || (rs1 == 5'd5);
    if (ld && !ls)      return OP_PUSH;
    else if (!ld && ls) return OP_POP;
    else if (ld && ls)  return (rd != rs1) ? OP_POPPUSH : OP_PUSH;
    else                return OP_NONE;
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  ras_op_e         op0, op1;
  entry_t          e0, e1;
  entry_t          head;
  logic [1:0]      head_op;
  logic            empty;
  logic            accept;
  logic            we0, we1;
  logic [1:0]      enq_n;
  logic            deq;
  logic [PW-1:0]   wr1_idx;

  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign head_op = head.op;

  // Ready depends only on the registered count so out_ready never reaches in_ready.
  assign bus.in_ready  = (count_q <= CW'(DEPTH - 2));
  assign bus.out_valid = !empty && !flush.valid;
  assign bus.out_op    = empty ? 2'b00 : head_op;
  assign bus.out_pc    = empty ? '0 : head.pc;

  always_comb begin
    op0     = classify(bus.in0_rd, bus.in0_rs1);
    op1     = classify(bus.in1_rd, bus.in1_rs1);
    e0      = '{op: op0, pc: bus.in0_pc};
    e1      = '{op: op1, pc: bus.in1_pc};
    accept  = clk_en && !flush.valid && bus.in_ready && (bus.in0_valid || bus.in1_valid);
    we0     = accept && bus.in0_valid && (op0 != OP_NONE);
    we1     = accept && bus.in1_valid && (op1 != OP_NONE);
    enq_n   = {1'b0, we0} + {1'b0, we1};
    wr1_idx = wr_ptr_q + PW'(we0);
    deq     = clk_en && !flush.valid && bus.out_valid && bus.out_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush.valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (clk_en) begin
      wr_ptr_d = wr_ptr_q + PW'(enq_n);
      rd_ptr_d = rd_ptr_q + PW'(deq);
      count_d  = count_q + CW'(enq_n) - CW'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Lane1 lands directly after lane0 when both carry an op, else at the write pointer.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_ptr_q] <= e0;
    if (we1) mem_q[wr1_idx]  <= e1;
  end

`ifdef RAS_SCHED_STATS_EN
  logic [15:0] stat_push_q, stat_pop_q, stat_flush_drop_q;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, stat_flush_drop_q} + 17'(count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_push_q       <= '0;
      stat_pop_q        <= '0;
      stat_flush_drop_q <= '0;
    end else if (flush.valid) begin
      stat_flush_drop_q <= drop_sum[16] ? '1 : drop_sum[15:0];
    end else if (deq) begin
      if (head_op[0] && (stat_push_q != '1)) stat_push_q <= stat_push_q + 16'd1;
      if (head_op[1] && (stat_pop_q != '1))  stat_pop_q  <= stat_pop_q + 16'd1;
    end
  end

  assign stat_push       = stat_push_q;
  assign stat_pop        = stat_pop_q;
  assign stat_flush_drop = stat_flush_drop_q;
`endif

endmodule

// File: tb/tb_ras_update_sched.sv
// Self-checking bench for ras_update_sched: directed scenarios then random traffic against a queue model.
module tb_ras_update_sched;
  import ras_update_sched_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic   clk = 1'b0;
  logic   rst;
  logic   clk_en;
  flush_t flush;

  ras_update_sched_if #(.WIDTH(WIDTH)) bus ();

`ifdef RAS_SCHED_STATS_EN
  logic [15:0] stat_push, stat_pop, stat_flush_drop;
`endif

  ras_update_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .flush  (flush),
    .bus    (bus)
`ifdef RAS_SCHED_STATS_EN
    ,
    .stat_push       (stat_push),
    .stat_pop        (stat_pop),
    .stat_flush_drop (stat_flush_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] pc;
  } item_t;

  item_t       mq[$];
  int unsigned m_push, m_pop, m_drop;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Link-register hint rules: 1=push, 2=pop, 3=pop-then-push, 0=nothing.
  function automatic logic [1:0] ref_op(input logic [4:0] rd, input logic [4:0] rs1);
    bit rd_link  = (rd == 1) || (rd == 5);
    bit rs1_link = (rs1 == 1) || (rs1 == 5);
    if (rd_link && rs1_link) return (rd == rs1) ? 2'd1 : 2'd3;
    if (rd_link)             return 2'd1;
    if (rs1_link)            return 2'd2;
    return 2'd0;
  endfunction

  task automatic set_lanes(input logic v0, input logic [4:0] rd0, input logic [4:0] rs0, input logic [31:0] pc0,
                           input logic v1, input logic [4:0] rd1, input logic [4:0] rs1, input logic [31:0] pc1);
    bus.in0_valid = v0; bus.in0_rd = rd0; bus.in0_rs1 = rs0; bus.in0_pc = pc0;
    bus.in1_valid = v1; bus.in1_rd = rd1; bus.in1_rs1 = rs1; bus.in1_pc = pc1;
  endtask

  // Called at posedge+1 with inputs driven; checks at negedge, advances model, returns at next posedge+1.
  task automatic step();
    item_t it;
    bit    ready;
    int    sz;
    @(negedge clk);
    sz    = mq.size();
    ready = (DEPTH - sz) >= 2;
    check("in_ready", bus.in_ready, ready);
    check("out_valid", bus.out_valid, (sz != 0) && !flush.valid);
    check("out_op", bus.out_op, (sz != 0) ? mq[0].op : 2'd0);
    check("out_pc", bus.out_pc, (sz != 0) ? mq[0].pc : 32'd0);
`ifdef RAS_SCHED_STATS_EN
    check("stat_push", stat_push, m_push);
    check("stat_pop", stat_pop, m_pop);
    check("stat_flush_drop", stat_flush_drop, m_drop);
`endif
    if (flush.valid) begin
      m_drop = (m_drop + sz > 65535) ? 65535 : m_drop + sz;
      mq.delete();
    end else if (clk_en) begin
      if (sz != 0 && bus.out_ready) begin
        it = mq.pop_front();
        if ((it.op == 1 || it.op == 3) && m_push < 65535) m_push++;
        if ((it.op == 2 || it.op == 3) && m_pop < 65535) m_pop++;
      end
      if (ready) begin
        if (bus.in0_valid && ref_op(bus.in0_rd, bus.in0_rs1) != 0)
          mq.push_back('{op: ref_op(bus.in0_rd, bus.in0_rs1), pc: bus.in0_pc});
        if (bus.in1_valid && ref_op(bus.in1_rd, bus.in1_rs1) != 0)
          mq.push_back('{op: ref_op(bus.in1_rd, bus.in1_rs1), pc: bus.in1_pc});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    flush.valid = 1'b0;
  endtask

  task automatic queue_three();
    bus.out_ready = 1'b0;
    set_lanes(1, 1, 0, 32'h1000, 1, 5, 0, 32'h1004); step();
    set_lanes(1, 1, 0, 32'h1008, 0, 0, 0, 0);        step();
    idle();
  endtask

  logic [4:0] regs [8];

  initial begin
    regs = '{5'd0, 5'd1, 5'd5, 5'd2, 5'd1, 5'd5, 5'd3, 5'd0};
    m_push = 0; m_pop = 0; m_drop = 0;
    rst = 1'b1; clk_en = 1'b1; flush.valid = 1'b0; bus.out_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_op", bus.out_op, 2'd0);

    // Single call
    bus.out_ready = 1'b1;
    set_lanes(1, 1, 0, 32'h104, 0, 0, 0, 0); step();
    idle();
    check("call_op", bus.out_op, 2'b01);
    check("call_pc", bus.out_pc, 32'h104);
    step();
    check("call_empty", bus.out_valid, 1'b0);

    // Return on lane0, pop-then-push on lane1
    set_lanes(1, 0, 1, 32'h200, 1, 5, 1, 32'h208); step();
    idle();
    check("ret_op", bus.out_op, 2'b10);
    step();
    check("pp_op", bus.out_op, 2'b11);
    check("pp_pc", bus.out_pc, 32'h208);
    step();

    // rd==rs1 link is a push; non-link pair enqueues nothing
    set_lanes(1, 5, 5, 32'h300, 0, 0, 0, 0); step();
    idle();
    check("same_link_op", bus.out_op, 2'b01);
    step();
    set_lanes(1, 2, 3, 32'h400, 0, 0, 0, 0); step();
    idle();
    check("nolink_valid", bus.out_valid, 1'b0);
    check("nolink_ready", bus.in_ready, 1'b1);

    // Fill with two calls per cycle while blocked, then drain
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_lanes(1, 1, 0, 32'h500 + 8 * i, 1, 1, 0, 32'h504 + 8 * i);
      step();
    end
    check("full_in_ready", bus.in_ready, 1'b0);
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Flush with 3 queued plus new lanes
    queue_three();
    set_lanes(1, 1, 0, 32'h600, 1, 1, 0, 32'h604);
    flush.valid = 1'b1;
    step();
    idle();
    check("flush_valid", bus.out_valid, 1'b0);
    check("flush_ready", bus.in_ready, 1'b1);
`ifdef RAS_SCHED_STATS_EN
    check("flush_drop3", stat_flush_drop, 16'd3);
`endif
    step();

    // Asynchronous reset with 3 queued
    queue_three();
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", bus.out_valid, 1'b0);
    check("midrst_ready", bus.in_ready, 1'b1);
    mq.delete(); m_push = 0; m_pop = 0; m_drop = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      clk_en        = ($urandom_range(0, 7) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush.valid   = clk_en && ($urandom_range(0, 19) == 0);
      set_lanes($urandom_range(0, 1), regs[$urandom_range(0, 7)], regs[$urandom_range(0, 7)], $urandom,
                $urandom_range(0, 1), regs[$urandom_range(0, 7)], regs[$urandom_range(0, 7)], $urandom);
      step();
    end
    clk_en = 1'b1;
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("final_empty", bus.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
